// File: rtl/mapping_crate_window.sv
// -----------------------------------------------------------------------------
// mapping_crate_window
//
// Purpose:
//   Collects hit words from NCH fibre channels over one frame into a window of
//   N_ROWS x ROW_W hit bitmaps for one crate. It then presents a 38-bit header
//   and the bitmaps for a single cycle.
//   Frame sequence after a sync word in IDLE:
//     SKIP (1 cycle)
//     ACCUM (FRAME_LEN cycles)
//     TRAIL (tag captured)
//     EMIT (outputs valid, bitmaps cleared)
//
// Ports:
//   clk           system clock
//   rst           synchronous, active-high reset
//   fiber[15:0]   fibre word: sync detection, tag source in TRAIL
//   ch_bus        NCH channel words, channel k = ch_bus[16k+15:16k]
//                 word fields: [12]=c, [11:6]=x_raw, [5:0]=y_raw
//   out_valid     one-cycle strobe, header and bitmaps valid
//   array_header  {1, CRATE_ID, tag, SYNC}, zero when out_valid is low
//   array_out     row r = array_out[ROW_W*r +: ROW_W], zero when out_valid is low
//   sync_err      sticky: sync word seen while a frame was in progress
//
// Optional feature (macro MAPPING_HIT_COUNT_EN):
//   Adds hit_cnt[9:0] and drop_cnt[9:0].
//   hit_cnt counts accepted hit words.
//   drop_cnt counts c=1 words rejected by the window check.
//   Both saturate at 1023 and are presented with out_valid, zero otherwise.
// -----------------------------------------------------------------------------
module mapping_crate_window #(
    parameter int          NCH       = 16,
    parameter int          ROW_W     = 38,
    parameter int          N_ROWS    = 8,
    parameter int          Y_BASE    = 11,
    parameter int          FRAME_LEN = 16,
    parameter logic [15:0] SYNC      = 16'hAAAA,
    parameter logic [10:0] CRATE_ID  = 11'h040
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [15:0]              fiber,
    input  logic [NCH*16-1:0]        ch_bus,
    output logic                     out_valid,
    output logic [37:0]              array_header,
    output logic [N_ROWS*ROW_W-1:0]  array_out,
    output logic                     sync_err
`ifdef MAPPING_HIT_COUNT_EN
    ,
    output logic [9:0]               hit_cnt,
    output logic [9:0]               drop_cnt
`endif
);

    localparam int RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int XW = (ROW_W > 1) ? $clog2(ROW_W) : 1;
    localparam logic [4:0] CNT_LAST = 5'(FRAME_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SKIP,
        S_ACCUM,
        S_TRAIL,
        S_EMIT
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [4:0]        r_cnt;
    logic              r_sync_err;
    logic [ROW_W-1:0]  r_bm   [N_ROWS];
    logic [ROW_W-1:0]  w_mask [N_ROWS];
    logic              r_vld_p0;
    logic [37:0]       r_header_p0;
    logic [N_ROWS*ROW_W-1:0] r_array_p0;
    logic              w_sync;
    logic              w_unused_bits;

    // Raw coordinates are stored minus one; the +1 wraps in 6 bits (63 -> 0).
    function automatic logic [5:0] inc6(input logic [5:0] v);
        return v + 6'd1;
    endfunction

    function automatic logic in_window(input logic [5:0] xr, input logic [5:0] yr);
        int xi;
        int yi;
        xi = int'(inc6(xr));
        yi = int'(inc6(yr));
        return (yi >= Y_BASE) && (yi < Y_BASE + N_ROWS) && (xi < ROW_W);
    endfunction

    function automatic logic [RW-1:0] row_of(input logic [5:0] yr);
        return RW'(int'(inc6(yr)) - Y_BASE);
    endfunction

    function automatic logic [XW-1:0] col_of(input logic [5:0] xr);
        return XW'(inc6(xr));
    endfunction

`ifdef MAPPING_HIT_COUNT_EN
    localparam int CNW = $clog2(NCH + 1);

    logic [CNW-1:0] w_nhit;
    logic [CNW-1:0] w_ndrop;
    logic [9:0]     r_hit_acc;
    logic [9:0]     r_drop_acc;
    logic [9:0]     r_hit_p0;
    logic [9:0]     r_drop_p0;

    function automatic logic [9:0] sat_add10(input logic [9:0] a, input logic [CNW-1:0] n);
        int s;
        s = int'(a) + int'(n);
        return (s > 1023) ? 10'd1023 : 10'(s);
    endfunction
`endif

    assign w_sync        = (fiber == SYNC);
    assign w_unused_bits = ^ch_bus;

    // Hit decode: per-cycle OR mask of accepted pixels across all channels
    always_comb begin
        for (int r = 0; r < N_ROWS; r++) begin
            w_mask[r] = '0;
        end
`ifdef MAPPING_HIT_COUNT_EN
        w_nhit  = '0;
        w_ndrop = '0;
`endif
        for (int k = 0; k < NCH; k++) begin
            if (ch_bus[16*k + 12]) begin
                if (in_window(ch_bus[16*k + 6 +: 6], ch_bus[16*k +: 6])) begin
                    w_mask[row_of(ch_bus[16*k +: 6])][col_of(ch_bus[16*k + 6 +: 6])] = 1'b1;
`ifdef MAPPING_HIT_COUNT_EN
                    w_nhit = w_nhit + CNW'(1);
                end else begin
                    w_ndrop = w_ndrop + CNW'(1);
`endif
                end
            end
        end
    end

    // Frame control
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_sync) w_next = S_SKIP;
            S_SKIP:  w_next = S_ACCUM;
            S_ACCUM: if (r_cnt == CNT_LAST) w_next = S_TRAIL;
            S_TRAIL: w_next = S_EMIT;
            S_EMIT:  w_next = w_sync ? S_SKIP : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 5'd0;
            r_sync_err <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == S_ACCUM) ? r_cnt + 5'd1 : 5'd0;
            if (w_sync && (r_state inside {S_SKIP, S_ACCUM, S_TRAIL})) begin
                r_sync_err <= 1'b1;
            end
        end
    end

    // Bitmap accumulation; EMIT empties the window for the next frame
    always_ff @(posedge clk) begin
        for (int r = 0; r < N_ROWS; r++) begin
            if (rst || (r_state == S_EMIT)) begin
                r_bm[r] <= '0;
            end else if (r_state == S_ACCUM) begin
                r_bm[r] <= r_bm[r] | w_mask[r];
            end
        end
    end

`ifdef MAPPING_HIT_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst || (r_state == S_EMIT)) begin
            r_hit_acc  <= 10'd0;
            r_drop_acc <= 10'd0;
        end else if (r_state == S_ACCUM) begin
            r_hit_acc  <= sat_add10(r_hit_acc, w_nhit);
            r_drop_acc <= sat_add10(r_drop_acc, w_ndrop);
        end
    end
`endif

    // Output register stage p0: loaded on the TRAIL -> EMIT edge, zero otherwise
    always_ff @(posedge clk) begin
        if (rst || (r_state != S_TRAIL)) begin
            r_vld_p0    <= 1'b0;
            r_header_p0 <= '0;
            r_array_p0  <= '0;
`ifdef MAPPING_HIT_COUNT_EN
            r_hit_p0    <= 10'd0;
            r_drop_p0   <= 10'd0;
`endif
        end else begin
            r_vld_p0    <= 1'b1;
            r_header_p0 <= {1'b1, CRATE_ID, fiber[9:0], SYNC};
            for (int r = 0; r < N_ROWS; r++) begin
                r_array_p0[ROW_W*r +: ROW_W] <= r_bm[r];
            end
`ifdef MAPPING_HIT_COUNT_EN
            r_hit_p0    <= r_hit_acc;
            r_drop_p0   <= r_drop_acc;
`endif
        end
    end

    assign out_valid    = r_vld_p0;
    assign array_header = r_header_p0;
    assign array_out    = r_array_p0;
    assign sync_err     = r_sync_err;
`ifdef MAPPING_HIT_COUNT_EN
    assign hit_cnt      = r_hit_p0;
    assign drop_cnt     = r_drop_p0;
`endif

endmodule

// File: tb/tb_mapping_crate_window.sv
`timescale 1ns/1ps
module tb_mapping_crate_window;

    localparam int          NCH       = 16;
    localparam int          ROW_W     = 38;
    localparam int          N_ROWS    = 8;
    localparam int          Y_BASE    = 11;
    localparam int          FRAME_LEN = 16;
    localparam logic [15:0] SYNC      = 16'hAAAA;
    localparam logic [10:0] CRATE_ID  = 11'h040;
    localparam int          AW        = N_ROWS * ROW_W;
    localparam int          CBW       = NCH * 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [15:0]    fiber;
    logic [CBW-1:0] ch_bus;
    logic           out_valid;
    logic [37:0]    array_header;
    logic [AW-1:0]  array_out;
    logic           sync_err;
`ifdef MAPPING_HIT_COUNT_EN
    logic [9:0]     hit_cnt;
    logic [9:0]     drop_cnt;
`endif

    always #5 clk = ~clk;

    mapping_crate_window #(
        .NCH(NCH), .ROW_W(ROW_W), .N_ROWS(N_ROWS), .Y_BASE(Y_BASE),
        .FRAME_LEN(FRAME_LEN), .SYNC(SYNC), .CRATE_ID(CRATE_ID)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fiber(fiber),
        .ch_bus(ch_bus),
        .out_valid(out_valid),
        .array_header(array_header),
        .array_out(array_out),
        .sync_err(sync_err)
`ifdef MAPPING_HIT_COUNT_EN
        ,
        .hit_cnt(hit_cnt),
        .drop_cnt(drop_cnt)
`endif
    );

    // Reference model state: m_ph is the frame phase of the cycle being driven
    // (-1 idle, 1 skip, 2..FRAME_LEN+1 accumulate, FRAME_LEN+2 trail, FRAME_LEN+3 emit).
    int            m_ph;
    bit            m_bm [N_ROWS][ROW_W];
    bit            m_err;
    int            m_hits;
    int            m_drops;
    logic          e_valid;
    logic [37:0]   e_hdr;
    logic [AW-1:0] e_arr;
    logic          e_err;
    logic [9:0]    e_hit;
    logic [9:0]    e_drop;

    int            checks;
    int            errors;
    bit            cmp_en;
    int            cyc;
    int            vld_last;
    int            vld_prev;
    logic [CBW-1:0] fr [FRAME_LEN];
    logic [AW-1:0]  lit;

    task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] sat10(input int v);
        return (v > 1023) ? 10'd1023 : 10'(v);
    endfunction

    task automatic model_clear();
        for (int r = 0; r < N_ROWS; r++)
            for (int b = 0; b < ROW_W; b++)
                m_bm[r][b] = 1'b0;
        m_hits  = 0;
        m_drops = 0;
    endtask

    task automatic model_step();
        logic [15:0] w;
        int x;
        int y;
        bit is_sync;
        e_valid = 1'b0;
        e_hdr   = '0;
        e_arr   = '0;
        e_hit   = '0;
        e_drop  = '0;
        if (rst) begin
            m_ph  = -1;
            m_err = 1'b0;
            model_clear();
        end else begin
            is_sync = (fiber == SYNC);
            if (m_ph >= 2 && m_ph <= FRAME_LEN + 1) begin
                for (int k = 0; k < NCH; k++) begin
                    w = ch_bus[16*k +: 16];
                    if (w[12]) begin
                        x = (int'(w[11:6]) + 1) % 64;
                        y = (int'(w[5:0]) + 1) % 64;
                        if (y >= Y_BASE && y < Y_BASE + N_ROWS && x < ROW_W) begin
                            m_bm[y - Y_BASE][x] = 1'b1;
                            m_hits++;
                        end else begin
                            m_drops++;
                        end
                    end
                end
            end
            if (m_ph == FRAME_LEN + 2) begin
                e_valid = 1'b1;
                e_hdr   = {1'b1, CRATE_ID, fiber[9:0], SYNC};
                for (int r = 0; r < N_ROWS; r++)
                    for (int b = 0; b < ROW_W; b++)
                        e_arr[r*ROW_W + b] = m_bm[r][b];
                e_hit  = sat10(m_hits);
                e_drop = sat10(m_drops);
            end
            if (m_ph == FRAME_LEN + 3) model_clear();
            if (is_sync && m_ph >= 1 && m_ph <= FRAME_LEN + 2) m_err = 1'b1;
            if (m_ph < 0 || m_ph == FRAME_LEN + 3) m_ph = is_sync ? 1 : -1;
            else m_ph++;
        end
        e_err = m_err;
    endtask

    task automatic compare_all();
        chk("out_valid", out_valid, e_valid);
        chk("array_header", array_header, e_hdr);
        chk("array_out", array_out, e_arr);
        chk("sync_err", sync_err, e_err);
`ifdef MAPPING_HIT_COUNT_EN
        chk("hit_cnt", hit_cnt, e_hit);
        chk("drop_cnt", drop_cnt, e_drop);
`endif
    endtask

    task automatic step(input logic r, input logic [15:0] f, input logic [CBW-1:0] cb);
        @(negedge clk);
        cyc++;
        if (cmp_en) compare_all();
        if (out_valid === 1'b1) begin
            vld_prev = vld_last;
            vld_last = cyc;
        end
        rst    = r;
        fiber  = f;
        ch_bus = cb;
        model_step();
    endtask

    function automatic logic [CBW-1:0] rand_bus();
        logic [CBW-1:0] v;
        for (int i = 0; i < CBW / 32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [15:0] rand_fiber();
        logic [15:0] v;
        v = 16'($urandom);
        return (v == SYNC) ? 16'h0000 : v;
    endfunction

    function automatic logic [15:0] mk(input logic c, input int xr, input int yr);
        return {3'b000, c, 6'(xr), 6'(yr)};
    endfunction

    function automatic logic [15:0] rand_hit();
        logic [5:0] xr;
        logic [5:0] yr;
        xr = 6'($urandom_range(0, 40));
        yr = ($urandom_range(0, 9) == 0) ? 6'd63 : 6'($urandom_range(6, 21));
        return {3'($urandom), 1'($urandom_range(0, 3) != 0), xr, yr};
    endfunction

    task automatic clear_fr();
        for (int i = 0; i < FRAME_LEN; i++) fr[i] = '0;
    endtask

    task automatic put(input int i, input int k, input logic [15:0] w);
        fr[i][16*k +: 16] = w;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0000, '0);
    endtask

    // Drives sync, skip, FRAME_LEN accumulate cycles and the trail cycle.
    task automatic send_frame(input logic [9:0] tag, input int sync_idx);
        step(1'b0, SYNC, rand_bus());
        step(1'b0, rand_fiber(), rand_bus());
        for (int i = 0; i < FRAME_LEN; i++)
            step(1'b0, (i == sync_idx) ? SYNC : rand_fiber(), fr[i]);
        step(1'b0, {6'h15, tag}, rand_bus());
    endtask

    initial begin
        checks = 0; errors = 0; cmp_en = 1'b0; cyc = 0;
        vld_last = 0; vld_prev = 0;
        m_ph = -1; m_err = 1'b0; model_clear();
        rst = 1'b1; fiber = '0; ch_bus = '0;

        // reset and long idle
        step(1'b1, 16'h0000, '0);
        cmp_en = 1'b1;
        step(1'b1, 16'h0000, '0);
        idle(100);
        chk("idle_out_valid", out_valid, 1'b0);
        chk("idle_header", array_header, 38'h0);
        chk("idle_sync_err", sync_err, 1'b0);

        // single hit: x_raw=4, y_raw=10 -> row0 bit5
        clear_fr();
        put(0, 0, 16'h110A);
        send_frame(10'h155, -1);
        chk("hit_pre_valid", out_valid, 1'b0);
        step(1'b0, 16'h0000, '0);
        chk("hit_valid", out_valid, 1'b1);
        chk("hit_header", array_header, 38'h210155AAAA);
        lit = '0; lit[5] = 1'b1;
        chk("hit_array", array_out, lit);
        step(1'b0, 16'h0000, '0);
        chk("hit_post_valid", out_valid, 1'b0);
        chk("hit_post_array", array_out, '0);

        // window boundaries
        idle(3);
        clear_fr();
        put(0, 0, mk(1, 0, 9));
        put(0, 1, mk(1, 0, 18));
        put(0, 2, mk(1, 0, 17));
        put(0, 3, mk(1, 37, 10));
        put(0, 4, mk(1, 36, 10));
        put(0, 5, mk(1, 0, 63));
        put(0, 6, mk(0, 0, 10));
        for (int i = 1; i < FRAME_LEN; i++) put(i, 7, mk(0, 3, 12));
        send_frame(10'h001, -1);
        step(1'b0, 16'h0000, '0);
        lit = '0; lit[7*ROW_W + 1] = 1'b1; lit[37] = 1'b1;
        chk("bnd_array", array_out, lit);
`ifdef MAPPING_HIT_COUNT_EN
        chk("bnd_hit_cnt", hit_cnt, 10'd2);
`endif

        // overlap: every channel, every cycle, same pixel -> row2 bit1
        idle(2);
        for (int i = 0; i < FRAME_LEN; i++)
            for (int k = 0; k < NCH; k++) put(i, k, 16'h100C);
        send_frame(10'h3FF, -1);
        step(1'b0, 16'h0000, '0);
        lit = '0; lit[2*ROW_W + 1] = 1'b1;
        chk("ovl_array", array_out, lit);
`ifdef MAPPING_HIT_COUNT_EN
        chk("ovl_hit_cnt", hit_cnt, 10'd256);
`endif

        // back-to-back frames: second sync on the EMIT cycle of the first
        idle(2);
        clear_fr();
        put(3, 2, mk(1, 2, 11));
        send_frame(10'h0AA, -1);
        clear_fr();
        put(4, 9, mk(1, 9, 13));
        send_frame(10'h0BB, -1);
        step(1'b0, 16'h0000, '0);
        chk("b2b_valid", out_valid, 1'b1);
        chk("b2b_gap", 32'(vld_last - vld_prev), 32'd19);
        lit = '0; lit[3*ROW_W + 10] = 1'b1;
        chk("b2b_array", array_out, lit);

        // sync during accumulate: flagged, timing unchanged
        idle(2);
        clear_fr();
        put(0, 0, 16'h110A);
        send_frame(10'h077, 5);
        step(1'b0, 16'h0000, '0);
        chk("serr_valid", out_valid, 1'b1);
        chk("serr_flag", sync_err, 1'b1);
        step(1'b1, 16'h0000, '0);
        step(1'b0, 16'h0000, '0);
        chk("serr_cleared", sync_err, 1'b0);

        // reset in the middle of a frame
        for (int i = 0; i < FRAME_LEN; i++) fr[i] = '0;
        step(1'b0, SYNC, '0);
        step(1'b0, 16'h0000, '0);
        for (int i = 0; i < 6; i++) step(1'b0, 16'h0000, {NCH{mk(1, 4, 10)}});
        step(1'b1, 16'h0000, {NCH{mk(1, 4, 10)}});
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 16'h0000, '0);
            chk("rstmid_no_valid", out_valid, 1'b0);
        end
        clear_fr();
        put(0, 0, 16'h110A);
        send_frame(10'h155, -1);
        step(1'b0, 16'h0000, '0);
        lit = '0; lit[5] = 1'b1;
        chk("rstmid_clean_array", array_out, lit);

        // randomized frames, gaps, stray syncs and resets
        for (int f = 0; f < 14; f++) begin
            int sidx;
            int gap;
            for (int i = 0; i < FRAME_LEN; i++)
                for (int k = 0; k < NCH; k++) put(i, k, rand_hit());
            sidx = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, FRAME_LEN - 1)) : -1;
            send_frame(10'($urandom), sidx);
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) step(1'b0, rand_fiber(), rand_bus());
            if ($urandom_range(0, 5) == 0) step(1'b1, rand_fiber(), rand_bus());
        end
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
